// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// helper that turns clock/baud rates into a bit period in clock cycles.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int DATA_BITS = 8;

    // Number of system clock cycles in one serial bit period.
    function automatic int bit_cycles(input int clk_frq, input int baud);
        return clk_frq / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit. Both flops reset to 1
// so an idle-high serial line looks idle straight out of reset.
module uart_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Detects the start-bit falling edge, re-checks the start
// bit half a period later, then samples each data bit and the stop bit in the
// middle of its bit period. A good frame produces a one-cycle rx_valid with
// the byte on rx_data; a low stop bit produces a one-cycle frame_err instead.
//
// Handshake: rx_valid is a one-cycle strobe with no ready/back-pressure; the
// consumer must capture rx_data on the cycle rx_valid is high. rx_data then
// holds until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRQ   = 100,
    parameter int BAUD_RATE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_enb,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int BIT  = bit_cycles(CLK_FRQ, BAUD_RATE);
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);

    localparam logic [CW-1:0] BIT_M1   = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

    // With fewer than 4 cycles per bit there is no usable mid-bit sample point.
    if (BIT < 4) begin : g_bit_check
        $error("uart_rx: CLK_FRQ/BAUD_RATE must be at least 4");
    end

    uart_rx_state_t       state_q;
    logic [CW-1:0]        cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 busy_q;
    logic                 rx_s;
    logic                 rx_d_q;

    uart_sync2 u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    // Delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_d_q <= 1'b1;
        end else begin
            rx_d_q <= rx_s;
        end
    end

    // Receive FSM with registered strobes, busy flag and data output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (!rx_enb) begin
                // Disabling abandons any frame in flight without a strobe.
                state_q   <= IDLE;
                cnt_q     <= '0;
                bit_idx_q <= '0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // Only a high-to-low transition starts a frame, so a
                        // line held low (break) cannot re-trigger.
                        if (!rx_s && rx_d_q) begin
                            state_q <= START;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_q == HALF_M1) begin
                            cnt_q <= '0;
                            if (!rx_s) begin
                                state_q   <= DATA;
                                bit_idx_q <= '0;
                            end else begin
                                // Line went back high: treat as a glitch.
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt_q == BIT_M1) begin
                            shift_q[bit_idx_q] <= rx_s;
                            cnt_q              <= '0;
                            if (bit_idx_q == LAST_IDX) begin
                                state_q   <= STOP;
                                bit_idx_q <= '0;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (cnt_q == BIT_M1) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (rx_s) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (10 cycles per bit).
// Inputs change 1 time unit after a rising edge; outputs are observed on the
// falling edge. Received bytes are checked against an expected queue.
module tb_uart_rx;

    localparam int BIT = 10;

    logic       clk;
    logic       rst;
    logic       rx_enb;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];

    int cyc            = 0;
    int frame_e0       = 0;
    int valid_cnt      = 0;
    int ferr_cnt       = 0;
    int busy_cnt       = 0;
    int last_valid_cyc = 0;
    int last_ferr_cyc  = 0;
    int busy_rise_cyc  = 0;
    logic busy_prev    = 1'b0;

    int snap_valid;
    int snap_ferr;
    int snap_busy;

    uart_rx #(
        .CLK_FRQ   (100),
        .BAUD_RATE (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_enb    (rx_enb),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard / pulse monitor on the falling edge
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (exp_q.size() > 0) begin
                check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end else begin
                check("unexpected_rx_valid", 32'd1, 32'd0);
            end
        end
        if (frame_err === 1'b1) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (busy === 1'b1) begin
            busy_cnt++;
            if (!busy_prev) busy_rise_cyc = cyc;
        end
        busy_prev = busy;
    end

    // Driver tasks: all called just after a rising edge
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_low(input int n);
        rx = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, stop bit; leaves rx at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        frame_e0 = cyc + 1;
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic snapshot();
        snap_valid = valid_cnt;
        snap_ferr  = ferr_cnt;
        snap_busy  = busy_cnt;
    endtask

    initial begin
        rst    = 1'b0;
        rx     = 1'b1;
        rx_enb = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", {24'h0, rx_data}, 32'h00);
        check("reset_rx_valid", {31'h0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'h0, frame_err}, 32'd0);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_state", {30'h0, dbg_state}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(10);

        // Good frame 0x5A: strobe in the cycle after E97
        snapshot();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(10);
        check("5a_valid_count", valid_cnt - snap_valid, 32'd1);
        check("5a_valid_timing", last_valid_cyc - frame_e0, 32'd97);
        check("5a_frame_err_count", ferr_cnt - snap_ferr, 32'd0);
        check("5a_busy_rise", busy_rise_cyc - frame_e0, 32'd2);
        check("5a_busy_cycles", busy_cnt - snap_busy, 32'd95);
        check("5a_rx_data_hold", {24'h0, rx_data}, 32'h5A);

        // Framing error 0xA5, then line held low as a break
        snapshot();
        send_frame(8'hA5, 1'b0);
        check("a5_frame_err_count", ferr_cnt - snap_ferr, 32'd1);
        check("a5_frame_err_timing", last_ferr_cyc - frame_e0, 32'd97);
        check("a5_no_valid", valid_cnt - snap_valid, 32'd0);
        check("a5_rx_data_kept", {24'h0, rx_data}, 32'h5A);
        snapshot();
        hold_low(30);
        check("break_no_busy", busy_cnt - snap_busy, 32'd0);
        idle(20);

        // 3-cycle glitch on an idle line
        snapshot();
        hold_low(3);
        idle(20);
        check("glitch_busy_cycles", busy_cnt - snap_busy, 32'd5);
        check("glitch_no_valid", valid_cnt - snap_valid, 32'd0);
        check("glitch_no_frame_err", ferr_cnt - snap_ferr, 32'd0);

        // Back-to-back 0x00 then 0xFF, second start HALF after first stop sample
        snapshot();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(10);
        check("b2b_valid_count", valid_cnt - snap_valid, 32'd2);
        check("b2b_second_timing", last_valid_cyc - frame_e0, 32'd97);
        check("b2b_rx_data", {24'h0, rx_data}, 32'hFF);

        // rx_enb dropped during bit 3 of 0x3C; re-enabled after the frame
        snapshot();
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (44) @(posedge clk);
                #1;
                rx_enb = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("enb_drop_busy", {31'h0, busy}, 32'd0);
                check("enb_drop_state", {30'h0, dbg_state}, 32'd0);
            end
        join
        idle(5);
        rx_enb = 1'b1;
        idle(10);
        check("enb_no_valid", valid_cnt - snap_valid, 32'd0);
        check("enb_no_frame_err", ferr_cnt - snap_ferr, 32'd0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        idle(10);
        check("c3_valid_count", valid_cnt - snap_valid, 32'd1);

        // One-cycle reset during bit 5 of 0xE7
        snapshot();
        fork
            send_frame(8'hE7, 1'b1);
            begin
                repeat (64) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("midrst_rx_data", {24'h0, rx_data}, 32'h00);
                check("midrst_busy", {31'h0, busy}, 32'd0);
                check("midrst_state", {30'h0, dbg_state}, 32'd0);
                check("midrst_strobes", {30'h0, rx_valid, frame_err}, 32'd0);
                @(negedge clk);
                rst = 1'b1;
            end
        join
        idle(10);
        check("midrst_no_valid", valid_cnt - snap_valid, 32'd0);
        check("midrst_no_frame_err", ferr_cnt - snap_ferr, 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(10);
        check("81_valid_count", valid_cnt - snap_valid, 32'd1);
        check("81_rx_data", {24'h0, rx_data}, 32'h81);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
